// File: rtl/bus_demux_1x4_if.sv
// ---------------------------------------------------------------------------
// bus_demux_1x4_if
// Request/response bundle between the core, the 1x4 router and its targets.
//
// Handshake rule for both request channels (req_* from the core, s_* to a
// target): a transfer happens on a rising clk edge where valid and ready are
// both 1. Once valid is raised its payload stays stable until that edge.
// Responses (rsp_valid, s_rvalid) are single-cycle pulses with no back-pressure.
//
// Signals:
//   req_valid/req_ready/req_addr/req_we/req_wdata/req_be : core request
//   rsp_valid/rsp_rdata/rsp_err                          : response to core
//   s_valid[4]/s_ready[4]                                : per-target handshake
//   s_addr/s_we/s_wdata/s_be                             : shared target payload
//   s_rvalid[4]/s_rdata[128]                             : per-target response
// Modports:
//   master : the environment side (core plus targets)
//   slave  : the router
// ---------------------------------------------------------------------------
interface bus_demux_1x4_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [3:0]  s_rvalid;
    logic [127:0] s_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  s_valid, s_addr, s_we, s_wdata, s_be,
        output s_ready, s_rvalid, s_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output s_valid, s_addr, s_we, s_wdata, s_be,
        input  s_ready, s_rvalid, s_rdata
    );
endinterface

// File: rtl/bus_demux_1x4.sv
// ---------------------------------------------------------------------------
// bus_demux_1x4
// Routes one core load/store request to one of four targets selected by
// req_addr[SEL_LSB+1:SEL_LSB], then returns that target's response. Only one
// transaction is outstanding; a hung target produces an error response after
// TIMEOUT cycles.
//
// Ports:
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   bus       : bus_demux_1x4_if.slave (core request/response + target side)
//   state_dbg : current FSM state (IDLE=0, REQ=1, RESP=2)
// ---------------------------------------------------------------------------
module bus_demux_1x4 #(
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    bus_demux_1x4_if.slave   bus,
    output logic [1:0]       state_dbg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT - 1);
    // Timer is 0 in the first REQ cycle, so firing at TIMEOUT-2 puts the error
    // response exactly TIMEOUT cycles after acceptance.
    localparam logic [TW-1:0] T_FIRE = TW'(TIMEOUT - 2);

    logic [1:0]    state;
    logic [1:0]    sel_q;
    logic [TW-1:0] timer;

    logic [1:0]  sel_now;
    logic        hit_ready;
    logic        hit_rvalid;
    logic        timeout_hit;
    logic [31:0] rdata_sel;

    assign sel_now     = bus.req_addr[SEL_LSB+1:SEL_LSB];
    assign hit_ready   = bus.s_ready[sel_q];
    assign hit_rvalid  = bus.s_rvalid[sel_q];
    assign timeout_hit = (timer == T_FIRE);
    assign rdata_sel   = bus.s_rdata[{sel_q, 5'b00000} +: 32];

    assign bus.req_ready = (state == IDLE);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            sel_q         <= 2'd0;
            timer         <= '0;
            bus.s_valid   <= 4'd0;
            bus.s_addr    <= 32'd0;
            bus.s_we      <= 1'b0;
            bus.s_wdata   <= 32'd0;
            bus.s_be      <= 4'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            if (state != IDLE && timer != T_MAX) begin
                timer <= timer + TW'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.s_addr  <= bus.req_addr;
                        bus.s_we    <= bus.req_we;
                        bus.s_wdata <= bus.req_wdata;
                        bus.s_be    <= bus.req_be;
                        bus.s_valid <= 4'b0001 << sel_now;
                        sel_q       <= sel_now;
                        timer       <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (hit_ready) begin
                        bus.s_valid <= 4'd0;
                        // A response in the handshake cycle completes at once.
                        if (hit_rvalid) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= bus.s_we ? 32'd0 : rdata_sel;
                            state         <= IDLE;
                        end else if (timeout_hit) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                            state         <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (timeout_hit) begin
                        bus.s_valid   <= 4'd0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                        state         <= IDLE;
                    end
                end
                RESP: begin
                    // Completion is checked first so it wins over a timeout.
                    if (hit_rvalid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.s_we ? 32'd0 : rdata_sel;
                        state         <= IDLE;
                    end else if (timeout_hit) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.s_valid <= 4'd0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_demux_1x4.sv
// ---------------------------------------------------------------------------
// tb_bus_demux_1x4
// Bench for bus_demux_1x4 with TIMEOUT=8. Each transaction is described by its
// target, direction and the target's ready/response delays; the expected
// response cycle, error flag and data come from those numbers alone.
// ---------------------------------------------------------------------------
module tb_bus_demux_1x4;
    localparam int TO = 8;

    logic       clk;
    logic       reset_n;
    logic [1:0] state_dbg;

    bus_demux_1x4_if bus_if ();

    bus_demux_1x4 #(.SEL_LSB(28), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    int vectors;
    int miscompares;
    logic [31:0] last_rdata;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] noise(input logic [1:0] sel, input logic full);
        logic [3:0] n;
        n = full ? 4'hF : 4'($urandom);
        return n & ~(4'b0001 << sel);
    endfunction

    // ---------------- drivers ----------------
    // Called at a negedge of a cycle in which the router is idle; returns at the
    // negedge of the response cycle, where the next request may be presented.
    task automatic run_txn(input logic [1:0] sel, input logic we, input int rdy_dly,
                           input int rv_dly, input logic full_noise,
                           input logic [31:0] tgt_rdata);
        logic [31:0] addr, wdata, exp_rdata, rd;
        logic [3:0]  be, exp_sv;
        logic        exp_err;
        int          k_done, exp_rsp;

        addr        = $urandom;
        addr[29:28] = sel;
        wdata       = $urandom;
        be          = 4'($urandom);
        k_done      = 1 + rdy_dly + rv_dly;
        if (k_done <= TO - 1) begin
            exp_rsp = k_done + 1;
            exp_err = 1'b0;
        end else begin
            exp_rsp = TO;
            exp_err = 1'b1;
        end
        exp_rdata = 32'd0;

        check_eq("req_ready_idle", {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        bus_if.req_we    = we;
        bus_if.req_wdata = wdata;
        bus_if.req_be    = be;

        for (int t = 1; t <= exp_rsp; t++) begin
            @(negedge clk);
            exp_sv = (t <= 1 + rdy_dly && t < exp_rsp) ? (4'b0001 << sel) : 4'd0;
            check_eq("s_valid", {28'd0, bus_if.s_valid}, {28'd0, exp_sv});
            if (exp_sv != 4'd0) begin
                check_eq("s_addr", bus_if.s_addr, addr);
                check_eq("s_we", {31'd0, bus_if.s_we}, {31'd0, we});
                check_eq("s_wdata", bus_if.s_wdata, wdata);
                check_eq("s_be", {28'd0, bus_if.s_be}, {28'd0, be});
            end
            if (t == exp_rsp) begin
                check_eq("rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
                check_eq("rsp_err", {31'd0, bus_if.rsp_err}, {31'd0, exp_err});
                check_eq("rsp_rdata", bus_if.rsp_rdata, exp_err ? 32'd0 : exp_rdata);
                check_eq("req_ready_rsp", {31'd0, bus_if.req_ready}, 32'd1);
                last_rdata = exp_err ? 32'd0 : exp_rdata;
            end else begin
                check_eq("rsp_valid_quiet", {31'd0, bus_if.rsp_valid}, 32'd0);
                check_eq("rsp_rdata_hold", bus_if.rsp_rdata, last_rdata);
                check_eq("req_ready_busy", {31'd0, bus_if.req_ready}, 32'd0);
            end
            if (t == 1) bus_if.req_valid = 1'b0;
            bus_if.s_ready  = noise(sel, full_noise);
            bus_if.s_rvalid = noise(sel, full_noise);
            bus_if.s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            if (t < exp_rsp) begin
                if (t == 1 + rdy_dly) bus_if.s_ready[sel] = 1'b1;
                if (t == k_done) begin
                    if (tgt_rdata != 32'd0) bus_if.s_rdata[32*int'(sel) +: 32] = tgt_rdata;
                    rd = bus_if.s_rdata[32*int'(sel) +: 32];
                    exp_rdata = we ? 32'd0 : rd;
                    bus_if.s_rvalid[sel] = 1'b1;
                end
            end
        end
    endtask

    // Idle cycles with unrestricted noise on every target: nothing may respond.
    task automatic idle(input int n);
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
            check_eq("idle_s_valid", {28'd0, bus_if.s_valid}, 32'd0);
            check_eq("idle_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
            check_eq("idle_rdata_hold", bus_if.rsp_rdata, last_rdata);
            bus_if.s_ready  = 4'($urandom);
            bus_if.s_rvalid = 4'($urandom);
        end
        bus_if.s_ready  = 4'd0;
        bus_if.s_rvalid = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_valid"}, {28'd0, bus_if.s_valid}, 32'd0);
        check_eq({tag, "_rsp_valid"}, {31'd0, bus_if.rsp_valid}, 32'd0);
        check_eq({tag, "_rsp_err"}, {31'd0, bus_if.rsp_err}, 32'd0);
        check_eq({tag, "_rsp_rdata"}, bus_if.rsp_rdata, 32'd0);
        check_eq({tag, "_s_addr"}, bus_if.s_addr, 32'd0);
        check_eq({tag, "_s_we"}, {31'd0, bus_if.s_we}, 32'd0);
        check_eq({tag, "_s_wdata"}, bus_if.s_wdata, 32'd0);
        check_eq({tag, "_s_be"}, {28'd0, bus_if.s_be}, 32'd0);
        check_eq({tag, "_req_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
    endtask

    // Read accepted, handshake done, reset pulsed while waiting for the response.
    task automatic reset_mid_resp(input logic [1:0] sel);
        logic [31:0] addr;
        addr        = $urandom;
        addr[29:28] = sel;
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        bus_if.req_we    = 1'b0;
        @(negedge clk);
        bus_if.req_valid     = 1'b0;
        bus_if.s_ready       = 4'd0;
        bus_if.s_ready[sel]  = 1'b1;
        @(negedge clk);
        bus_if.s_ready = 4'd0;
        reset_n        = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset_n              = 1'b1;
        bus_if.s_rvalid[sel] = 1'b1;
        @(negedge clk);
        check_eq("rst_no_rsp", {31'd0, bus_if.rsp_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.s_rvalid = 4'd0;
        last_rdata = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        last_rdata  = 32'd0;
        reset_n          = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 32'd0;
        bus_if.req_we    = 1'b0;
        bus_if.req_wdata = 32'd0;
        bus_if.req_be    = 4'd0;
        bus_if.s_ready   = 4'd0;
        bus_if.s_rvalid  = 4'd0;
        bus_if.s_rdata   = 128'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(2);

        // Minimum-latency read from target 2.
        run_txn(2'd2, 1'b0, 0, 0, 1'b0, 32'hCAFE_F00D);
        idle(1);
        // Write to target 0 with ready delayed 3 cycles.
        run_txn(2'd0, 1'b1, 3, 1, 1'b0, 32'd0);
        idle(1);
        // Target 1 selected, all other targets hammering ready/rvalid.
        run_txn(2'd1, 1'b0, 2, 2, 1'b1, 32'd0);
        idle(1);
        // Target 3 never answers; late rvalid during idle must be dropped.
        run_txn(2'd3, 1'b0, 100, 0, 1'b0, 32'd0);
        idle(4);
        // Completion in the last cycle before the timeout fires.
        run_txn(2'd1, 1'b0, 3, 3, 1'b0, 32'd0);
        // Back-to-back requests, each accepted in the previous response cycle.
        run_txn(2'd2, 1'b0, 1, 0, 1'b0, 32'd0);
        run_txn(2'd0, 1'b0, 0, 1, 1'b0, 32'd0);
        idle(1);
        reset_mid_resp(2'd1);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 32'd0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
